// File: rtl/adder_chunk_seq.sv
// rtl/adder_chunk_seq.sv - multi-cycle chunked add/subtract unit with start/busy/done handshake
// Sums WIDTH-bit operands CHUNK bits per clock, LSB chunk first, carry registered between chunks.
module adder_chunk_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic             co,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic              co_q, co_d;
  logic              ovf_q, ovf_d;

  logic [CHUNK-1:0]  a_ch;
  logic [CHUNK-1:0]  b_ch;
  logic [CHUNK:0]    sum_c;
  logic              accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      q_q     <= q_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  // Chunk select: constant slices picked by the chunk index keep every select in range.
  always_comb begin
    a_ch = '0;
    b_ch = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (idx_q == IDXW'(k)) begin
        a_ch = a_q[k*CHUNK +: CHUNK];
        b_ch = b_q[k*CHUNK +: CHUNK];
      end
    end
    sum_c = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_q};
  end

  assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    q_d     = q_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    co_d    = co_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          // Subtract is a + ~b + ~ci, so borrow-in becomes an inverted carry-in.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? ~ci : ci;
          idx_d   = '0;
          q_d     = '0;
          co_d    = 1'b0;
          ovf_d   = 1'b0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        for (int k = 0; k < NCHUNK; k++) begin
          if (idx_q == IDXW'(k)) begin
            q_d[k*CHUNK +: CHUNK] = sum_c[CHUNK-1:0];
          end
        end
        carry_d = sum_c[CHUNK];
        if (idx_q == LAST_IDX) begin
          co_d    = sum_c[CHUNK];
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_c[CHUNK-1] != a_q[WIDTH-1]);
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign q    = q_q;
  assign co   = co_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_adder_chunk_seq.sv
// tb/tb_adder_chunk_seq.sv - scoreboard bench for adder_chunk_seq in three width/chunk configurations
// Instance 0: 16/4, instance 1: 8/8, instance 2: 12/3; a negedge monitor pops expected results.
module tb_adder_chunk_seq;

  typedef struct {
    logic [15:0] q;
    logic        co;
    logic        ovf;
    longint      due;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [2:0]  start;
  logic [2:0]  sub_v;
  logic [2:0]  ci_v;
  logic [15:0] a_v [3];
  logic [15:0] b_v [3];
  logic [2:0]  busy_w;
  logic [2:0]  done_w;
  logic [2:0]  co_w;
  logic [2:0]  ovf_w;
  logic [15:0] q0;
  logic [7:0]  q1;
  logic [11:0] q2;
  logic [15:0] q_w [3];

  int          wid [3] = '{16, 8, 12};
  int          nch [3] = '{4, 1, 4};
  exp_t        sb [3][$];
  longint      cyc;
  int          total;
  int          bad;

  adder_chunk_seq #(.WIDTH(16), .CHUNK(4)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .sub(sub_v[0]), .a(a_v[0]), .b(b_v[0]),
    .ci(ci_v[0]), .busy(busy_w[0]), .done(done_w[0]), .q(q0), .co(co_w[0]), .ovf(ovf_w[0])
  );
  adder_chunk_seq #(.WIDTH(8), .CHUNK(8)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .sub(sub_v[1]), .a(a_v[1][7:0]), .b(b_v[1][7:0]),
    .ci(ci_v[1]), .busy(busy_w[1]), .done(done_w[1]), .q(q1), .co(co_w[1]), .ovf(ovf_w[1])
  );
  adder_chunk_seq #(.WIDTH(12), .CHUNK(3)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .sub(sub_v[2]), .a(a_v[2][11:0]), .b(b_v[2][11:0]),
    .ci(ci_v[2]), .busy(busy_w[2]), .done(done_w[2]), .q(q2), .co(co_w[2]), .ovf(ovf_w[2])
  );

  assign q_w[0] = q0;
  assign q_w[1] = {8'h00, q1};
  assign q_w[2] = {4'h0, q2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the unsigned and signed readings of the operands.
  task automatic model(input int i, input bit s, input logic [15:0] x, input logic [15:0] y,
                       input bit c, output logic [15:0] mq, output bit mco, output bit mov);
    longint m, ux, uy, sx, sy, u, sr;
    m  = longint'(1) << wid[i];
    ux = longint'(x);
    uy = longint'(y);
    sx = (ux >= m / 2) ? ux - m : ux;
    sy = (uy >= m / 2) ? uy - m : uy;
    if (!s) begin
      u   = ux + uy + longint'(c);
      sr  = sx + sy + longint'(c);
      mco = (u >= m);
    end else begin
      u   = ux - uy - longint'(c);
      sr  = sx - sy - longint'(c);
      mco = (u >= 0);
    end
    mq  = 16'((u + 2 * m) % m);
    mov = (sr > m / 2 - 1) || (sr < -(m / 2));
  endtask

  // Called either just after a rising edge or in the DONE cycle; the next edge accepts.
  task automatic issue(input int i, input bit s, input logic [15:0] x, input logic [15:0] y,
                       input bit c, input logic [15:0] eq, input bit eco, input bit eov);
    exp_t e;
    sub_v[i] = s;
    a_v[i]   = x;
    b_v[i]   = y;
    ci_v[i]  = c;
    start[i] = 1'b1;
    e.q   = eq;
    e.co  = eco;
    e.ovf = eov;
    e.due = cyc + 1 + nch[i];
    sb[i].push_back(e);
    @(posedge clk);
    #1;
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, output int bc);
    bc = 0;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (busy_w[i]) bc++;
      if (done_w[i]) return;
    end
    chk($sformatf("done_timeout[%0d]", i), 0, 1);
  endtask

  task automatic dir16(input bit s, input logic [15:0] x, input logic [15:0] y, input bit c,
                       input logic [15:0] eq, input bit eco, input bit eov);
    int bc;
    issue(0, s, x, y, c, eq, eco, eov);
    wait_done(0, bc);
    chk("busy_cycles", bc, 4);
  endtask

  task automatic rand_ops(input int i, input int n);
    logic [15:0] x, y, mq;
    bit          s, c, mco, mov;
    int          bc;
    longint      mask;
    mask = (longint'(1) << wid[i]) - 1;
    for (int k = 0; k < n; k++) begin
      x = 16'($urandom & 32'(mask));
      y = 16'($urandom & 32'(mask));
      s = 1'($urandom);
      c = 1'($urandom);
      if (k % 7 == 0) begin
        x = 16'(mask);
        y = (k % 2 == 0) ? 16'(mask) : 16'h0001;
      end
      model(i, s, x, y, c, mq, mco, mov);
      issue(i, s, x, y, c, mq, mco, mov);
      if (nch[i] > 1 && $urandom_range(0, 2) == 0) begin
        a_v[i]   = 16'($urandom);
        b_v[i]   = 16'($urandom);
        sub_v[i] = ~s;
        ci_v[i]  = ~c;
        start[i] = 1'b1;
        @(posedge clk);
        #1;
        start[i] = 1'b0;
      end
      wait_done(i, bc);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        chk($sformatf("reset_outputs[%0d]", i),
            longint'({busy_w[i], done_w[i], q_w[i], co_w[i], ovf_w[i]}), 0);
      end else if (done_w[i]) begin
        chk($sformatf("busy_with_done[%0d]", i), longint'(busy_w[i]), 0);
        if (sb[i].size() == 0) begin
          chk($sformatf("unexpected_done[%0d]", i), 1, 0);
        end else begin
          e = sb[i].pop_front();
          chk($sformatf("q[%0d]", i), longint'(q_w[i]), longint'(e.q));
          chk($sformatf("co[%0d]", i), longint'(co_w[i]), longint'(e.co));
          chk($sformatf("ovf[%0d]", i), longint'(ovf_w[i]), longint'(e.ovf));
          chk($sformatf("latency[%0d]", i), cyc, e.due);
        end
      end
    end
  end

  initial begin
    int bc;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    start = '0;
    sub_v = '0;
    ci_v  = '0;
    for (int i = 0; i < 3; i++) begin
      a_v[i] = '0;
      b_v[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    dir16(1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    dir16(1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
    dir16(1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    dir16(1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    dir16(1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    dir16(1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    dir16(1'b1, 16'h0010, 16'h0001, 1'b1, 16'h000E, 1'b1, 1'b0);

    // Starts while busy must not disturb the captured operands.
    issue(0, 1'b0, 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);
    a_v[0] = 16'hDEAD; b_v[0] = 16'hBEEF; sub_v[0] = 1'b1; start[0] = 1'b1;
    @(posedge clk); #1; start[0] = 1'b0;
    @(posedge clk); #1; a_v[0] = 16'hFFFF; ci_v[0] = 1'b1; start[0] = 1'b1;
    @(posedge clk); #1; start[0] = 1'b0;
    wait_done(0, bc);
    dir16(1'b0, 16'hA000, 16'h6000, 1'b0, 16'h0000, 1'b1, 1'b0);

    // Abort in the second RUN cycle; the pending result is discarded.
    @(posedge clk); #1;
    issue(0, 1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb[0].delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    dir16(1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);

    @(posedge clk); #1;
    rand_ops(0, 300);
    @(posedge clk); #1;
    rand_ops(1, 1000);
    @(posedge clk); #1;
    rand_ops(2, 1000);

    repeat (8) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("leftover_expected[%0d]", i), longint'(sb[i].size()), 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
